// File: rtl/mu0_pkg.sv
// Shared MU0 definitions: bus width defaults, instruction opcodes and the
// boot-loader state encoding used by the memory responder.
package mu0_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [3:0] {
      OP_LDA = 4'h0,
      OP_STO = 4'h1,
      OP_ADD = 4'h2,
      OP_SUB = 4'h3,
      OP_JMP = 4'h4,
      OP_JGE = 4'h5,
      OP_JNE = 4'h6,
      OP_STP = 4'h7
   } opcode_t;

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } ld_state_t;

endpackage

// File: rtl/ram_2r1w_sync.sv
// Storage array with one write port and two registered, read-first read ports.
// Each read port holds its last word when its enable is low; i_clr zeroes both.
module ram_2r1w_sync #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
) (
   input  logic              i_clk,
   input  logic              i_clr,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re_a,
   input  logic [ADDR_W-1:0] i_raddr_a,
   output logic [DATA_W-1:0] o_rdata_a,
   input  logic              i_re_b,
   input  logic [ADDR_W-1:0] i_raddr_b,
   output logic [DATA_W-1:0] o_rdata_b
);

   logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] r_rdata_a;
   logic [DATA_W-1:0] r_rdata_b;

   always_ff @(posedge i_clk) begin
      if (i_we)
         r_mem[i_waddr] <= i_wdata;
   end

   // Reads sample the array before this edge's write lands, giving old data.
   always_ff @(posedge i_clk) begin
      if (i_clr)
         r_rdata_a <= '0;
      else if (i_re_a)
         r_rdata_a <= r_mem[i_raddr_a];
   end

   always_ff @(posedge i_clk) begin
      if (i_clr)
         r_rdata_b <= '0;
      else if (i_re_b)
         r_rdata_b <= r_mem[i_raddr_b];
   end

   assign o_rdata_a = r_rdata_a;
   assign o_rdata_b = r_rdata_b;

endmodule

// File: rtl/mem_mu0_delay1.sv
// MU0 bus memory responder with a boot loader: streams an image into memory,
// holds the CPU in reset until done, then serves port A (r/w) and port B (r).
module mem_mu0_delay1
   import mu0_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] address,
   input  logic              write,
   input  logic              read,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] readdata,
   input  logic [ADDR_W-1:0] address2,
   output logic [DATA_W-1:0] readdata2,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              cpu_rst,
   output logic              loading,
   output logic              collision
);

   ld_state_t         r_state;
   ld_state_t         w_state_nxt;
   logic [ADDR_W-1:0] r_load_ptr;
   logic              r_collision;
   logic              w_hs;
   logic              w_ptr_max;
   logic              w_run;
   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic [DATA_W-1:0] w_wdata;

   assign w_run     = (r_state == RUN);
   assign w_hs      = !w_run && load_valid;
   assign w_ptr_max = (r_load_ptr == {ADDR_W{1'b1}});

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= LOAD;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == LOAD && w_hs && (load_last || w_ptr_max))
         w_state_nxt = RUN;
   end

   // Control outputs decode straight from the state flop, so cpu_rst is glitch-free.
   always_comb begin
      load_ready = 1'b0;
      cpu_rst    = 1'b0;
      loading    = 1'b0;
      w_we       = 1'b0;
      w_waddr    = address;
      w_wdata    = writedata;
      if (r_state == LOAD) begin
         load_ready = 1'b1;
         cpu_rst    = 1'b1;
         loading    = 1'b1;
         w_we       = w_hs && !rst;
         w_waddr    = r_load_ptr;
         w_wdata    = load_data;
      end else begin
         w_we       = write && !rst;
      end
   end

   // The pointer stops at the top address rather than wrapping to 0.
   always_ff @(posedge clk) begin
      if (rst)
         r_load_ptr <= '0;
      else if (w_hs && !w_ptr_max)
         r_load_ptr <= r_load_ptr + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_collision <= 1'b0;
      else if (w_run && read && write)
         r_collision <= 1'b1;
   end

   assign collision = r_collision;

   ram_2r1w_sync #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .i_clk     (clk),
      .i_clr     (rst),
      .i_we      (w_we),
      .i_waddr   (w_waddr),
      .i_wdata   (w_wdata),
      .i_re_a    (w_run && read),
      .i_raddr_a (address),
      .o_rdata_a (readdata),
      .i_re_b    (w_run),
      .i_raddr_b (address2),
      .o_rdata_b (readdata2)
   );

endmodule

// File: tb/tb_mem_mu0_delay1.sv
// Directed bench for mem_mu0_delay1: boot load, port A/B timing, collisions,
// mid-run reset and a full-depth load.
module tb_mem_mu0_delay1;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] address;
   logic        write;
   logic        read;
   logic [15:0] writedata;
   logic [15:0] readdata;
   logic [11:0] address2;
   logic [15:0] readdata2;
   logic        load_valid;
   logic [15:0] load_data;
   logic        load_last;
   logic        load_ready;
   logic        cpu_rst;
   logic        loading;
   logic        collision;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_mu0_delay1 dut (
      .clk        (clk),
      .rst        (rst),
      .address    (address),
      .write      (write),
      .read       (read),
      .writedata  (writedata),
      .readdata   (readdata),
      .address2   (address2),
      .readdata2  (readdata2),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_last  (load_last),
      .load_ready (load_ready),
      .cpu_rst    (cpu_rst),
      .loading    (loading),
      .collision  (collision)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; address = '0; write = 0; read = 0; writedata = '0;
      address2 = '0; load_valid = 0; load_data = '0; load_last = 0;
      tick(); tick();
      n_checks++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_rst got %b want 1", cpu_rst); end
      n_checks++; if (loading !== 1'b1) begin n_fail++; $display("FAIL reset_loading got %b want 1", loading); end
      n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_load_ready got %b want 1", load_ready); end
      n_checks++; if (readdata !== 16'h0) begin n_fail++; $display("FAIL reset_readdata got %h want 0000", readdata); end
      n_checks++; if (readdata2 !== 16'h0) begin n_fail++; $display("FAIL reset_readdata2 got %h want 0000", readdata2); end
      n_checks++; if (collision !== 1'b0) begin n_fail++; $display("FAIL reset_collision got %b want 0", collision); end
   endtask

   task automatic test_load3;
      logic [15:0] words [3];
      words[0] = 16'h0005; words[1] = 16'h7000; words[2] = 16'h1234;
      rst = 1'b0;
      // CPU bus activity while loading must be ignored.
      address = 12'h005; write = 1; read = 1; writedata = 16'hFFFF;
      for (int i = 0; i < 3; i++) begin
         load_valid = 1; load_data = words[i]; load_last = (i == 2);
         n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL load3_ready[%0d] got %b want 1", i, load_ready); end
         n_checks++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL load3_cpu_rst[%0d] got %b want 1", i, cpu_rst); end
         tick();
      end
      n_checks++; if (readdata !== 16'h0) begin n_fail++; $display("FAIL load3_rd_hold got %h want 0000", readdata); end
      n_checks++; if (collision !== 1'b0) begin n_fail++; $display("FAIL load3_collision got %b want 0", collision); end
      load_valid = 0; load_last = 0; write = 0; read = 0;
      n_checks++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL load3_cpu_rst_fall got %b want 0", cpu_rst); end
      n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL load3_ready_low got %b want 0", load_ready); end
      n_checks++; if (loading !== 1'b0) begin n_fail++; $display("FAIL load3_loading_low got %b want 0", loading); end
      for (int i = 0; i < 3; i++) begin
         address = 12'(i); read = 1;
         tick();
         n_checks++; if (readdata !== words[i]) begin n_fail++; $display("FAIL load3_read[%0d] got %h want %h", i, readdata, words[i]); end
      end
      read = 0;
   endtask

   task automatic test_write_read;
      address = 12'h010; write = 1; writedata = 16'hBEEF;
      tick();
      write = 0; read = 1;
      tick();
      n_checks++; if (readdata !== 16'hBEEF) begin n_fail++; $display("FAIL wr_rd got %h want beef", readdata); end
      read = 0; address = 12'h000;
      tick(); tick();
      n_checks++; if (readdata !== 16'hBEEF) begin n_fail++; $display("FAIL wr_rd_hold got %h want beef", readdata); end
   endtask

   task automatic test_collision;
      address = 12'h002; read = 1; write = 1; writedata = 16'hAAAA;
      tick();
      n_checks++; if (readdata !== 16'h1234) begin n_fail++; $display("FAIL coll_old got %h want 1234", readdata); end
      n_checks++; if (collision !== 1'b1) begin n_fail++; $display("FAIL coll_flag got %b want 1", collision); end
      write = 0;
      tick();
      n_checks++; if (readdata !== 16'hAAAA) begin n_fail++; $display("FAIL coll_new got %h want aaaa", readdata); end
      n_checks++; if (collision !== 1'b1) begin n_fail++; $display("FAIL coll_sticky got %b want 1", collision); end
      read = 0;
   endtask

   task automatic test_portb;
      address2 = 12'h001; address = 12'h001; write = 1; writedata = 16'h5555;
      tick();
      n_checks++; if (readdata2 !== 16'h7000) begin n_fail++; $display("FAIL portb_old got %h want 7000", readdata2); end
      write = 0;
      tick();
      n_checks++; if (readdata2 !== 16'h5555) begin n_fail++; $display("FAIL portb_new got %h want 5555", readdata2); end
   endtask

   task automatic test_rst_mid_run;
      // Store as the CPU would with STO, then confirm it survives a reload.
      address = 12'h020; write = 1; writedata = 16'h4321;
      tick();
      write = 0; read = 1;
      tick();
      n_checks++; if (readdata !== 16'h4321) begin n_fail++; $display("FAIL mid_sto got %h want 4321", readdata); end
      rst = 1; address = 12'h010; read = 1;
      tick();
      n_checks++; if (readdata !== 16'h0) begin n_fail++; $display("FAIL mid_rd_zero got %h want 0000", readdata); end
      n_checks++; if (readdata2 !== 16'h0) begin n_fail++; $display("FAIL mid_rd2_zero got %h want 0000", readdata2); end
      n_checks++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL mid_cpu_rst got %b want 1", cpu_rst); end
      n_checks++; if (collision !== 1'b0) begin n_fail++; $display("FAIL mid_coll_clr got %b want 0", collision); end
      rst = 0; read = 0;
      load_valid = 1; load_data = 16'h1111; load_last = 0;
      tick();
      load_data = 16'h2222; load_last = 1;
      n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reload_ready got %b want 1", load_ready); end
      tick();
      load_valid = 0; load_last = 0;
      n_checks++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL mid_reload_run got %b want 0", cpu_rst); end
      read = 1;
      address = 12'h000; tick();
      n_checks++; if (readdata !== 16'h1111) begin n_fail++; $display("FAIL mid_read0 got %h want 1111", readdata); end
      address = 12'h001; tick();
      n_checks++; if (readdata !== 16'h2222) begin n_fail++; $display("FAIL mid_read1 got %h want 2222", readdata); end
      address = 12'h002; tick();
      n_checks++; if (readdata !== 16'hAAAA) begin n_fail++; $display("FAIL mid_read2 got %h want aaaa", readdata); end
      address = 12'h020; tick();
      n_checks++; if (readdata !== 16'h4321) begin n_fail++; $display("FAIL mid_kept got %h want 4321", readdata); end
      read = 0;
   endtask

   task automatic test_full_load;
      logic [15:0] exp;
      rst = 1; tick(); rst = 0;
      for (int i = 0; i < 4096; i++) begin
         load_valid = 1; load_last = 0; load_data = 16'(i * 3 + 7);
         n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready[%0d] got %b want 1", i, load_ready); end
         tick();
      end
      // Extra valid words after the top address must be ignored.
      load_data = 16'hDEAD;
      n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_low got %b want 0", load_ready); end
      n_checks++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL full_cpu_rst got %b want 0", cpu_rst); end
      tick(); tick();
      load_valid = 0;
      n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_stay got %b want 0", load_ready); end
      read = 1;
      address = 12'hFFF; tick(); exp = 16'(4095 * 3 + 7);
      n_checks++; if (readdata !== exp) begin n_fail++; $display("FAIL full_top got %h want %h", readdata, exp); end
      address = 12'h000; tick(); exp = 16'(7);
      n_checks++; if (readdata !== exp) begin n_fail++; $display("FAIL full_zero got %h want %h", readdata, exp); end
      address = 12'h020; address2 = 12'h800; tick();
      exp = 16'(32 * 3 + 7);
      n_checks++; if (readdata !== exp) begin n_fail++; $display("FAIL full_020 got %h want %h", readdata, exp); end
      exp = 16'(2048 * 3 + 7);
      n_checks++; if (readdata2 !== exp) begin n_fail++; $display("FAIL full_portb got %h want %h", readdata2, exp); end
      read = 0;
   endtask

   initial begin
      test_reset();
      test_load3();
      test_write_read();
      test_collision();
      test_portb();
      test_rst_mid_run();
      test_full_load();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
